// File: rtl/eth_tx_arb_if.sv
// Ethernet header + 8-bit AXI-Stream payload bundle used on each arbiter port.
// master drives header/payload, slave returns the two ready signals.
interface eth_tx_arb_if;
    logic        eth_hdr_valid;
    logic        eth_hdr_ready;
    logic [47:0] eth_dest_mac;
    logic [47:0] eth_src_mac;
    logic [15:0] eth_type;
    logic [7:0]  eth_payload_axis_tdata;
    logic        eth_payload_axis_tvalid;
    logic        eth_payload_axis_tready;
    logic        eth_payload_axis_tlast;
    logic        eth_payload_axis_tuser;

    modport master (
        output eth_hdr_valid, eth_dest_mac, eth_src_mac, eth_type,
        output eth_payload_axis_tdata, eth_payload_axis_tvalid,
        output eth_payload_axis_tlast, eth_payload_axis_tuser,
        input  eth_hdr_ready, eth_payload_axis_tready
    );

    modport slave (
        input  eth_hdr_valid, eth_dest_mac, eth_src_mac, eth_type,
        input  eth_payload_axis_tdata, eth_payload_axis_tvalid,
        input  eth_payload_axis_tlast, eth_payload_axis_tuser,
        output eth_hdr_ready, eth_payload_axis_tready
    );
endinterface

// File: rtl/eth_tx_arb.sv
// Two-port Ethernet TX frame arbiter (port 0 ARP, port 1 IP) with optional idle gap.
// Define ETH_TX_ARB_RR_EN for round-robin ties; default is fixed priority (port 0 wins).
module eth_tx_arb #(
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    eth_tx_arb_if.slave      s0,
    eth_tx_arb_if.slave      s1,
    eth_tx_arb_if.master     m,
    output logic             busy,
    output logic [1:0]       grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(IDLE_GAP);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_gap_cnt;
    logic [7:0]  w_gap_cnt_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic        r_hdr_valid;
    logic [47:0] r_dest_mac;
    logic [47:0] r_src_mac;
    logic [15:0] r_type;

    logic [1:0]  w_req;
    logic [1:0]  w_win;
    logic        w_hdr_accept;
    logic        w_last_xfer;

`ifdef ETH_TX_ARB_RR_EN
    // Port that wins the next simultaneous request.
    logic        r_rr_ptr;
`endif

    assign w_req = {s1.eth_hdr_valid, s0.eth_hdr_valid};

    always_comb begin
        w_win = '0;
`ifdef ETH_TX_ARB_RR_EN
        if (w_req == 2'b11) begin
            w_win = r_rr_ptr ? 2'b10 : 2'b01;
        end else begin
            w_win = w_req;
        end
`else
        if (w_req[0]) begin
            w_win = 2'b01;
        end else if (w_req[1]) begin
            w_win = 2'b10;
        end
`endif
    end

    // Payload path: pure combinational mux from the granted port while in FRAME.
    always_comb begin
        m.eth_payload_axis_tdata  = '0;
        m.eth_payload_axis_tvalid = 1'b0;
        m.eth_payload_axis_tlast  = 1'b0;
        m.eth_payload_axis_tuser  = 1'b0;
        s0.eth_payload_axis_tready = 1'b0;
        s1.eth_payload_axis_tready = 1'b0;
        if (r_state == FRAME && !rst) begin
            if (r_grant[0]) begin
                m.eth_payload_axis_tdata   = s0.eth_payload_axis_tdata;
                m.eth_payload_axis_tvalid  = s0.eth_payload_axis_tvalid;
                m.eth_payload_axis_tlast   = s0.eth_payload_axis_tlast;
                m.eth_payload_axis_tuser   = s0.eth_payload_axis_tuser;
                s0.eth_payload_axis_tready = m.eth_payload_axis_tready;
            end else if (r_grant[1]) begin
                m.eth_payload_axis_tdata   = s1.eth_payload_axis_tdata;
                m.eth_payload_axis_tvalid  = s1.eth_payload_axis_tvalid;
                m.eth_payload_axis_tlast   = s1.eth_payload_axis_tlast;
                m.eth_payload_axis_tuser   = s1.eth_payload_axis_tuser;
                s1.eth_payload_axis_tready = m.eth_payload_axis_tready;
            end
        end
    end

    assign w_last_xfer = m.eth_payload_axis_tvalid & m.eth_payload_axis_tready &
                         m.eth_payload_axis_tlast;

    always_comb begin
        w_state_nxt       = r_state;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_grant_nxt       = r_grant;
        w_hdr_accept      = 1'b0;
        s0.eth_hdr_ready  = 1'b0;
        s1.eth_hdr_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                // A pending output header blocks acceptance of the next one.
                if (!r_hdr_valid && !rst) begin
                    s0.eth_hdr_ready = w_win[0];
                    s1.eth_hdr_ready = w_win[1];
                    if (|w_win) begin
                        w_hdr_accept = 1'b1;
                        w_grant_nxt  = w_win;
                        w_state_nxt  = FRAME;
                    end
                end
            end
            FRAME: begin
                if (w_last_xfer) begin
                    w_grant_nxt = '0;
                    if (IDLE_GAP == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt   = GAP;
                        w_gap_cnt_nxt = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt <= 8'd1) begin
                    w_state_nxt   = IDLE;
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_gap_cnt_nxt = '0;
                w_grant_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
            r_grant   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_grant   <= w_grant_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_valid <= 1'b0;
            r_dest_mac  <= '0;
            r_src_mac   <= '0;
            r_type      <= '0;
        end else if (w_hdr_accept) begin
            r_hdr_valid <= 1'b1;
            r_dest_mac  <= w_win[1] ? s1.eth_dest_mac : s0.eth_dest_mac;
            r_src_mac   <= w_win[1] ? s1.eth_src_mac  : s0.eth_src_mac;
            r_type      <= w_win[1] ? s1.eth_type     : s0.eth_type;
        end else if (r_hdr_valid && m.eth_hdr_ready) begin
            r_hdr_valid <= 1'b0;
        end
    end

`ifdef ETH_TX_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_hdr_accept) begin
            r_rr_ptr <= w_win[0];
        end
    end
`endif

    assign m.eth_hdr_valid = r_hdr_valid;
    assign m.eth_dest_mac  = r_dest_mac;
    assign m.eth_src_mac   = r_src_mac;
    assign m.eth_type      = r_type;
    assign busy            = (r_state != IDLE);
    assign grant           = r_grant;

endmodule
